pwm_channel: RTL and testbench

Single PWM output stage downstream of the clock divider. Consumes the divider's one-cycle tick as a count enable, runs a period counter, and drives a registered PWM output from double-buffered period/duty registers. Register writes land in pending shadows and take effect only at a period boundary, so the waveform never glitches mid-period.

---
 rtl/pwm_channel_if.sv | 43 ++++
 rtl/pwm_channel.sv | 144 ++++++++++++++
 tb/tb_pwm_channel.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_channel_if.sv
// pwm_channel_if
// Bundles the register-write bus, the divider tick and the PWM outputs of one
// PWM channel. clk and rst_n are kept as plain ports on the modules.
//
// Signals:
//   tick        count enable from the clock divider, one clk wide
//   wr          register write strobe, one clk wide
//   addr        register select: 0 period, 1 duty, 2 control, 3 unused
//   wdata       write data; control uses bit0 = enable, bit1 = polarity
//   pwm_out     registered PWM waveform
//   period_done one-cycle pulse one clk after each period wrap
//
// Modports:
//   master  drives tick/wr/addr/wdata, observes the outputs (bus owner, bench)
//   slave   the PWM channel itself
interface pwm_channel_if #(
    parameter int WIDTH = 8
);
    logic             tick;
    logic             wr;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic             pwm_out;
    logic             period_done;

    modport master (
        output tick,
        output wr,
        output addr,
        output wdata,
        input  pwm_out,
        input  period_done
    );

    modport slave (
        input  tick,
        input  wr,
        input  addr,
        input  wdata,
        output pwm_out,
        output period_done
    );
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel
// Single PWM output stage fed by the clock divider's one-cycle tick.
// A WIDTH-bit period counter advances on each tick while enabled and wraps
// after period_act + 1 ticks. Period and duty are double buffered: bus writes
// land in pending shadows and are copied to the active registers only at a
// wrap (or continuously while disabled), so a running period never glitches.
// Enable and polarity take effect on the edge after they are written.
//
// Ports:
//   clk    system clock (shared with the divider)
//   rst_n  synchronous active-low reset, priority over all bus activity
//   bus    pwm_channel_if slave modport (tick, wr, addr, wdata, pwm_out,
//          period_done)
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_channel_if.slave  bus
);

    localparam logic [1:0] ADDR_PERIOD  = 2'd0;
    localparam logic [1:0] ADDR_DUTY    = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Pending shadows written by the bus.
    logic [WIDTH-1:0] period_pend_q, period_pend_d;
    logic [WIDTH-1:0] duty_pend_q,   duty_pend_d;
    // Active values seen by the counter and comparator.
    logic [WIDTH-1:0] period_act_q,  period_act_d;
    logic [WIDTH-1:0] duty_act_q,    duty_act_d;
    // Control, effective immediately.
    logic             en_q,          en_d;
    logic             pol_q,         pol_d;
    // Period counter.
    logic [WIDTH-1:0] cnt_q,         cnt_d;
    // Registered outputs.
    logic             pwm_out_q,     pwm_out_d;
    logic             period_done_q, period_done_d;

    // Counter has reached the end of the active period.
    logic             at_end_s;
    // Counter is in the active part of the period (before polarity).
    logic             active_s;

    // Terminal-count and duty compare, plain unsigned WIDTH-bit arithmetic.
    always_comb begin
        at_end_s = (cnt_q == period_act_q);
        active_s = (cnt_q < duty_act_q);
    end

    // Next-state logic: bus writes, counting, shadow load and output compare.
    always_comb begin
        period_pend_d = period_pend_q;
        duty_pend_d   = duty_pend_q;
        period_act_d  = period_act_q;
        duty_act_d    = duty_act_q;
        en_d          = en_q;
        pol_d         = pol_q;
        cnt_d         = cnt_q;

        // Bus writes only touch the pending shadows and control.
        if (bus.wr) begin
            case (bus.addr)
                ADDR_PERIOD:  period_pend_d = bus.wdata;
                ADDR_DUTY:    duty_pend_d   = bus.wdata;
                ADDR_CONTROL: begin
                    en_d  = bus.wdata[0];
                    pol_d = bus.wdata[1];
                end
                default: begin
                    // addr 3 is unused; writes are dropped.
                    period_pend_d = period_pend_q;
                end
            endcase
        end else begin
            period_pend_d = period_pend_q;
        end

        // Counting uses the current en_q, so a control write on a tick edge
        // does not change how that tick is handled. Shadow loads read the
        // _q pending values, so a write on the wrap edge waits one period.
        if (en_q) begin
            if (bus.tick) begin
                if (at_end_s) begin
                    cnt_d        = CNT_ZERO;
                    period_act_d = period_pend_q;
                    duty_act_d   = duty_pend_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            // Parked: counter at zero, active values track pending so that
            // enabling starts a clean period with the latest settings.
            cnt_d        = CNT_ZERO;
            period_act_d = period_pend_q;
            duty_act_d   = duty_pend_q;
        end

        // Output lags the counter by one clk; idle level is the polarity.
        if (en_q) begin
            pwm_out_d = active_s ^ pol_q;
        end else begin
            pwm_out_d = pol_q;
        end

        period_done_d = en_q & bus.tick & at_end_s;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_pend_q <= CNT_ZERO;
            duty_pend_q   <= CNT_ZERO;
            period_act_q  <= CNT_ZERO;
            duty_act_q    <= CNT_ZERO;
            en_q          <= 1'b0;
            pol_q         <= 1'b0;
            cnt_q         <= CNT_ZERO;
            pwm_out_q     <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            period_pend_q <= period_pend_d;
            duty_pend_q   <= duty_pend_d;
            period_act_q  <= period_act_d;
            duty_act_q    <= duty_act_d;
            en_q          <= en_d;
            pol_q         <= pol_d;
            cnt_q         <= cnt_d;
            pwm_out_q     <= pwm_out_d;
            period_done_q <= period_done_d;
        end
    end

    assign bus.pwm_out     = pwm_out_q;
    assign bus.period_done = period_done_q;

endmodule

// File: tb/tb_pwm_channel.sv
// Scoreboard bench for pwm_channel. Stimulus pushes hand-written expected
// waveforms (one character per clk edge) stamped with the edge number; a
// monitor pops and compares on the falling edge after each stamped edge.
module tb_pwm_channel;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int    cyc;
        logic  pwm;
        logic  pd;
        string name;
        int    idx;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t it;

    pwm_channel_if #(.WIDTH(8)) bus ();

    pwm_channel #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the edge just taken.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            checks++;
            if (bus.pwm_out !== it.pwm || bus.period_done !== it.pd) begin
                failures++;
                $display("FAIL %s[%0d] at edge %0d: got pwm_out=%b period_done=%b, required pwm_out=%b period_done=%b",
                         it.name, it.idx, cyc, bus.pwm_out, bus.period_done, it.pwm, it.pd);
            end
        end
    end

    function automatic string rep(string s, int n);
        string r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    // Queue expectations for the next pwm.len() edges.
    task automatic exp_pat(string name, string pwm, string pd);
        sb_item_t e;
        for (int i = 0; i < pwm.len(); i++) begin
            e.cyc  = cyc + 1 + i;
            e.pwm  = (pwm[i] == 8'h31);
            e.pd   = (pd[i] == 8'h31);
            e.name = name;
            e.idx  = i;
            sb.push_back(e);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(logic [1:0] a, logic [7:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cycles(1);
        bus.wr    = 1'b0;
    endtask

    task automatic setup(logic [7:0] p, logic [7:0] d, logic [7:0] c);
        write(2'd0, p);
        write(2'd1, d);
        write(2'd2, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_pat("reset_pulse", "0", "0");
        cycles(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.tick  = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 8'd0;
        @(posedge clk);
        #1;

        // Reset with tick and wr toggling: writes must be ignored.
        exp_pat("reset_hold", "00", "00");
        bus.tick = 1'b1; bus.wr = 1'b1; bus.addr = 2'd2; bus.wdata = 8'h03;
        cycles(1);
        bus.tick = 1'b0; bus.wr = 1'b1; bus.addr = 2'd1; bus.wdata = 8'h05;
        cycles(1);
        rst_n = 1'b1; bus.wr = 1'b0; bus.tick = 1'b1;
        exp_pat("idle", rep("0", 8), rep("0", 8));
        cycles(8);

        // Undivided tick, period 9 / duty 3.
        setup(8'd9, 8'd3, 8'd1);
        exp_pat("basic", rep("1110000000", 3), rep("0000000001", 3));
        cycles(30);
        do_reset();

        // Duty change mid-period, then a duty write on the wrap edge.
        setup(8'd9, 8'd3, 8'd1);
        exp_pat("glitch_free", {"1110000000", rep("1111111000", 2), "1111100000"},
                rep("0000000001", 4));
        cycles(5);
        write(2'd1, 8'd7);
        cycles(13);
        write(2'd1, 8'd5);
        cycles(20);
        do_reset();

        // Tick every 4th clk, period 3 / duty 2.
        bus.tick = 1'b0;
        setup(8'd3, 8'd2, 8'd1);
        exp_pat("divided",
                {"11111", rep({"00000000", "11111111"}, 2), "00000000", "111"},
                {rep("0", 12), "1", rep("0", 15), "1", rep("0", 15), "1", "000"});
        for (int i = 0; i < 48; i++) begin
            bus.tick = (i % 4 == 0);
            cycles(1);
        end
        bus.tick = 1'b1;
        do_reset();

        // Edge duties, normal polarity.
        setup(8'd9, 8'd0, 8'd1);
        exp_pat("duty0", rep("0", 20), rep("0000000001", 2));
        cycles(20);
        do_reset();
        setup(8'd9, 8'd200, 8'd1);
        exp_pat("duty200", rep("1", 20), rep("0000000001", 2));
        cycles(20);
        do_reset();

        // Edge duties, inverted polarity.
        setup(8'd9, 8'd0, 8'd3);
        exp_pat("duty0_inv", rep("1", 20), rep("0000000001", 2));
        cycles(20);
        do_reset();
        setup(8'd9, 8'd200, 8'd3);
        exp_pat("duty200_inv", rep("0", 20), rep("0000000001", 2));
        cycles(20);
        do_reset();

        // Period 0: wrap every tick; then invert, then disable (idle = pol).
        setup(8'd0, 8'd1, 8'd1);
        exp_pat("period0", {rep("1", 11), rep("0", 6), rep("1", 5)},
                {rep("1", 17), rep("0", 5)});
        cycles(10);
        write(2'd2, 8'd3);
        cycles(5);
        write(2'd2, 8'd2);
        cycles(5);
        do_reset();

        // Reset at cnt = 6: no period_done, registers cleared (duty 0 after
        // re-enable gives constant low with a wrap every tick).
        setup(8'd9, 8'd3, 8'd1);
        exp_pat("reset_mid", {"111", rep("0", 25)}, {rep("0", 18), rep("1", 10)});
        cycles(6);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(10);
        write(2'd2, 8'd1);
        cycles(10);

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycles(1);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
